seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Run controller for serial sequence detection. Loads a masked pattern through a valid/ready config port.
//  On start, monitors serial input a (qualified by a_valid) for a bounded window and counts overlapping
//  matches. Ends the run when the threshold or the window is reached. Sits between host config logic
//  and the serial bit stream; replaces the fixed-pattern detector with a programmable, scheduled run.
// PARAMETERS
//  PAT_W  8   pattern length in bits (>=2); pattern MSB = oldest bit
//  WIN_W  16  width of window-length field / window counter
//  CNT_W  8   width of threshold field / match counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  cfg_valid    in   1      config beat valid
//  cfg_ready    out  1      config accepted; =1 only in IDLE (combinational from state)
//  cfg_pattern  in   PAT_W  pattern to match
//  cfg_mask     in   PAT_W  1 = don't-care bit
//  cfg_window   in   WIN_W  run length in valid bits; 0 = unlimited
//  cfg_thresh   in   CNT_W  stop after this many matches; 0 = never stop on count
//  start        in   1      begin run (sampled in IDLE only)
//  abort        in   1      terminate run immediately, no done
//  a            in   1      serial data bit
//  a_valid      in   1      a is valid this cycle
//  match        out  1      1-cycle pulse per detected pattern
//  match_cnt    out  CNT_W  matches in current/last run, saturating
//  busy         out  1      run in progress (FILL or RUN)
//  done         out  1      1-cycle pulse at normal run end
//  hit          out  1      level: last run ended with threshold reached
// BEHAVIOUR
//  Reset: state IDLE; match/done/busy/hit=0, match_cnt=0, shift reg=0; config regs pattern=0, mask=0,
//   window=0, thresh=0. cfg_ready=1 after reset.
//  Config: cfg_valid&&cfg_ready latches all cfg_* fields at the edge. No effect outside IDLE (ready=0).
//  FSM: IDLE -start&&!abort-> FILL. A config beat in the same cycle as start is used by that run.
//   FILL: shifts in PAT_W-1 valid bits with no compare -> RUN.
//   RUN: each valid bit shifts in (shreg<={shreg[PAT_W-2:0],a}) and is compared:
//    ((shreg_next ^ pattern) & ~mask)==0.
//   abort in FILL/RUN -> IDLE next edge; busy drops, no done, match_cnt/hit held.
//  start in FILL/RUN is ignored; start&&abort in IDLE -> stay IDLE.
//  Run entry (IDLE->FILL) clears match_cnt, hit, window counter, shift reg.
//  Counting: a_valid=0 cycles hold all state. Window counter counts every valid bit from FILL onward.
//  Match: registered; pulses the cycle after the completing bit is sampled (latency 1). Overlaps allowed.
//   match_cnt increments in the same edge and saturates at 2^CNT_W-1.
//  Termination, evaluated on the edge that samples a valid bit:
//   - (thresh!=0 && new match_cnt==thresh) or (window!=0 && bits seen==window) -> IDLE.
//   - done pulses on the cycle after that edge, coincident with any final match pulse.
//   - hit <= threshold condition.
//   - If both conditions hold on the same bit: done=1, hit=1.
//  window < PAT_W: run ends in FILL; done=1, match_cnt=0.
//  Window and thresh both 0: runs until abort.
//  rst_n assertion mid-run returns to reset values at once, independent of clk.
// STRUCTURE
//  seq_detect_pkg:
//   - state_e enum {IDLE, FILL, RUN}
//   - default PAT_W/WIN_W/CNT_W localparams
//  Sub-module seq_shift_cmp: PAT_W shift register + masked compare.
//   - Ports: en, clr, a, pattern, mask, eq.
//  Top keeps FSM, window/match counters, config regs.
// TESTING
//  1 PAT_W=4 pat=1011 mask=0 win=0 thr=2; bits 1,0,1,1,0,1,1 ->
//    match after bits 4 and 7, match_cnt=2; done+hit with 2nd match; busy=0 next.
//  2 pat=1011 win=5 thr=3; bits 0,0,0,0,0 -> done after 5th bit, hit=0, match_cnt=0, no match.
//  3 pat=1001 mask=0110 thr=1; bits 1,1,1,1 -> match+done+hit after bit 4.
//  4 Test 1 with a_valid=0 gaps of 1-3 cycles between bits -> identical match/done sequence, delayed by gaps.
//  5 Busy: cfg_valid -> cfg_ready=0, config unchanged. abort after bit 2 -> busy=0 next cycle, no done.
//    start&&abort in IDLE -> stays IDLE.
//  6 rst_n low mid-RUN after 1 match -> all outputs 0 asynchronously; cfg_ready=1; next start behaves as fresh.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the programmable sequence-detect run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;   // pattern length in bits, MSB = oldest bit
    localparam int WIN_W_DEF = 16;  // window-length field / window counter width
    localparam int CNT_W_DEF = 8;   // threshold field / match counter width

    // IDLE: accepts config and start.
    // FILL: primes the shift register, no compare.
    // RUN : compares every valid bit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config port bundle for seq_detect_ctrl: one valid/ready beat carries pattern, mask, window, threshold.
// Latency: n/a (wires only).
// Backpressure: the slave holds cfg_ready low while a run is in progress; the master keeps the beat until accepted.
//
// Signals:
//   cfg_valid    master->slave  config beat valid
//   cfg_ready    slave->master  beat accepted on this edge
//   cfg_pattern  master->slave  pattern to match
//   cfg_mask     master->slave  1 = don't-care bit
//   cfg_window   master->slave  run length in valid bits, 0 = unlimited
//   cfg_thresh   master->slave  stop after this many matches, 0 = never stop on count
interface seq_detect_ctrl_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic [WIN_W-1:0] cfg_window;
    logic [CNT_W-1:0] cfg_thresh;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_mask,
        output cfg_window,
        output cfg_thresh,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_mask,
        input  cfg_window,
        input  cfg_thresh,
        output cfg_ready
    );

endinterface

// File: rtl/seq_shift_cmp.sv
// PAT_W-bit serial shift register with a masked compare of the value it is about to hold.
// Latency: eq is combinational on the current input bit; the shift takes effect on the clock edge.
// Backpressure: none; shifts only when en is high, clr has priority over en.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           shift a in on this edge
//   clr          zero the shift register on this edge
//   a            serial bit (newest lands in bit 0)
//   pattern      compare pattern, MSB = oldest bit
//   mask         1 = don't-care bit
//   eq           shift-register-with-a-shifted-in equals pattern on all unmasked bits
module seq_shift_cmp
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             eq
);

    logic [PAT_W-1:0] shreg_q;
    logic [PAT_W-1:0] shreg_d;
    logic [PAT_W-1:0] shreg_nxt;

    // Compare against the post-shift value so the match can be registered
    // on the same edge that samples the completing bit.
    assign shreg_nxt = {shreg_q[PAT_W-2:0], a};
    assign eq        = ((shreg_nxt ^ pattern) & ~mask) == '0;

    always_comb begin
        shreg_d = shreg_q;
        if (clr) begin
            shreg_d = '0;
        end else if (en) begin
            shreg_d = shreg_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for serial sequence detection: programmable masked pattern, bounded window, match threshold.
// Latency: match/done pulse one cycle after the edge that samples the completing bit.
// Backpressure: cfg_ready is high only in IDLE; the serial stream is never stalled, a_valid=0 simply holds state.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg          config beat (slave side of seq_detect_ctrl_if)
//   start        begin a run (honoured in IDLE only, ignored if abort is also high)
//   abort        end the run at once, no done pulse
//   a, a_valid   serial bit and its qualifier
//   match        1-cycle pulse per detected (overlapping) pattern
//   match_cnt    saturating match count of the current/last run
//   busy         run in progress
//   done         1-cycle pulse at normal run end (threshold or window)
//   hit          level: last run ended on the threshold
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_detect_ctrl_if.slave cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             a,
    input  logic             a_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             hit
);

    // Number of bits that must be primed before the first compare.
    localparam logic [WIN_W-1:0] FILL_LEN = WIN_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;

    logic             sh_en;
    logic             sh_clr;
    logic             eq;

    logic [WIN_W-1:0] bits_seen;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_new;
    logic             thr_reach;
    logic             win_reach;

    seq_shift_cmp #(
        .PAT_W (PAT_W)
    ) u_shift_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sh_en),
        .clr     (sh_clr),
        .a       (a),
        .pattern (pattern_q),
        .mask    (mask_q),
        .eq      (eq)
    );

    // Termination terms for the bit being sampled this cycle. They are
    // only acted on when a valid bit is consumed in FILL/RUN.
    // With an unlimited window the counter is allowed to wrap: it is then
    // never compared against the window and FILL is long over.
    assign bits_seen = win_cnt_q + 1'b1;
    assign cnt_inc   = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
    assign cnt_new   = eq ? cnt_inc : match_cnt_q;
    assign thr_reach = (thresh_q != '0) && (cnt_new == thresh_q);
    assign win_reach = (window_q != '0) && (bits_seen == window_q);

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        mask_d      = mask_q;
        window_d    = window_q;
        thresh_d    = thresh_q;
        win_cnt_d   = win_cnt_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        done_d      = 1'b0;
        hit_d       = hit_q;
        sh_en       = 1'b0;
        sh_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A beat accepted alongside start is the config that run uses.
                if (cfg.cfg_valid) begin
                    pattern_d = cfg.cfg_pattern;
                    mask_d    = cfg.cfg_mask;
                    window_d  = cfg.cfg_window;
                    thresh_d  = cfg.cfg_thresh;
                end
                if (start && !abort) begin
                    state_d     = FILL;
                    win_cnt_d   = '0;
                    match_cnt_d = '0;
                    hit_d       = 1'b0;
                    sh_clr      = 1'b1;
                end
            end

            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (a_valid) begin
                    sh_en     = 1'b1;
                    win_cnt_d = bits_seen;
                    // A window shorter than the pattern ends here with no compare.
                    if (win_reach) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hit_d   = 1'b0;
                    end else if (bits_seen == FILL_LEN) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (a_valid) begin
                    sh_en       = 1'b1;
                    win_cnt_d   = bits_seen;
                    match_d     = eq;
                    match_cnt_d = cnt_new;
                    if (thr_reach || win_reach) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hit_d   = thr_reach;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            mask_q      <= '0;
            window_q    <= '0;
            thresh_q    <= '0;
            win_cnt_q   <= '0;
            match_cnt_q <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
            window_q    <= window_d;
            thresh_q    <= thresh_d;
            win_cnt_q   <= win_cnt_d;
            match_cnt_q <= match_cnt_d;
            match_q     <= match_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign match         = match_q;
    assign match_cnt     = match_cnt_q;
    assign done          = done_q;
    assign hit           = hit_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus randomized runs against a bit-history model.
// Latency: expectations are taken one cycle after inputs are applied.
// Backpressure: config beats offered while busy must be dropped by the design.
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    localparam int PW = 4;
    localparam int WW = 8;
    localparam int CW = 3;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          a = 1'b0;
    logic          a_valid = 1'b0;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done;
    logic          hit;

    seq_detect_ctrl_if #(.PAT_W(PW), .WIN_W(WW), .CNT_W(CW)) cif ();

    seq_detect_ctrl #(.PAT_W(PW), .WIN_W(WW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cif.slave),
        .start     (start),
        .abort     (abort),
        .a         (a),
        .a_valid   (a_valid),
        .match     (match),
        .match_cnt (match_cnt),
        .busy      (busy),
        .done      (done),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: a run is a list of valid bits seen since start;
    // a match is any window of the last PW bits equal to the pattern on
    // unmasked positions, once at least PW bits exist.
    bit m_active;
    int m_seen;
    int m_cnt;
    bit m_hit;
    int m_pat, m_mask, m_win, m_thr;
    bit hist[$];
    bit e_match, e_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_seen = 0; m_cnt = 0; m_hit = 0;
        m_pat = 0; m_mask = 0; m_win = 0; m_thr = 0;
        e_match = 0; e_done = 0;
        hist.delete();
    endtask

    task automatic set_cfg(input int pat, input int msk, input int win, input int thr);
        cif.cfg_pattern = PW'(pat);
        cif.cfg_mask    = PW'(msk);
        cif.cfg_window  = WW'(win);
        cif.cfg_thresh  = CW'(thr);
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_match"}, 32'(match), 32'(e_match));
        check_val({tag, "_done"}, 32'(done), 32'(e_done));
        check_val({tag, "_busy"}, 32'(busy), 32'(m_active));
        check_val({tag, "_hit"}, 32'(hit), 32'(m_hit));
        check_val({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
        check_val({tag, "_rdy"}, 32'(cif.cfg_ready), 32'(!m_active));
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit cv, input bit st, input bit ab, input bit av, input bit aa, input string tag);
        bit ok, thr, wn;
        cif.cfg_valid = cv; start = st; abort = ab; a_valid = av; a = aa;
        e_match = 0; e_done = 0;
        if (!m_active) begin
            if (cv) begin
                m_pat = int'(cif.cfg_pattern); m_mask = int'(cif.cfg_mask);
                m_win = int'(cif.cfg_window);  m_thr  = int'(cif.cfg_thresh);
            end
            if (st && !ab) begin
                m_active = 1; m_seen = 0; m_cnt = 0; m_hit = 0;
                hist.delete();
            end
        end else if (ab) begin
            m_active = 0;
        end else if (av) begin
            hist.push_back(aa);
            if (hist.size() > PW) void'(hist.pop_front());
            m_seen++;
            if (m_seen >= PW) begin
                ok = 1;
                for (int k = 0; k < PW; k++) begin
                    if (((m_mask >> k) & 1) == 0 && hist[hist.size()-1-k] != bit'((m_pat >> k) & 1))
                        ok = 0;
                end
                if (ok) begin
                    e_match = 1;
                    if (m_cnt < CNT_SAT) m_cnt++;
                end
            end
            thr = (m_thr != 0) && (m_cnt == m_thr);
            wn  = (m_win != 0) && (m_seen == m_win);
            if (thr || wn) begin
                m_active = 0; e_done = 1; m_hit = thr;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic feed(input int n, input logic [15:0] bits, input string tag);
        // bits[n-1] is sent first
        for (int i = n - 1; i >= 0; i--) cyc(0, 0, 0, 1, bits[i], tag);
    endtask

    initial begin
        logic [15:0] b7;
        model_reset();
        cif.cfg_valid = 0;
        set_cfg(0, 0, 0, 0);
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        #4;

        // 1: overlapping matches, threshold 2, config beat together with start
        set_cfg(4'b1011, 0, 0, 2);
        cyc(1, 1, 0, 0, 0, "t1_start");
        b7 = 16'b1011011;
        feed(7, b7, "t1");
        check_val("t1_final_cnt", 32'(match_cnt), 32'd2);
        check_val("t1_final_hit", 32'(hit), 32'd1);
        cyc(0, 0, 0, 0, 0, "t1_idle");

        // 2: window end with no match
        set_cfg(4'b1011, 0, 5, 3);
        cyc(1, 1, 0, 0, 0, "t2_start");
        feed(5, 16'b00000, "t2");
        check_val("t2_final_hit", 32'(hit), 32'd0);
        check_val("t2_final_done", 32'(done), 32'd1);

        // 3: masked pattern, threshold 1
        set_cfg(4'b1001, 4'b0110, 0, 1);
        cyc(1, 1, 0, 0, 0, "t3_start");
        feed(4, 16'b1111, "t3");
        check_val("t3_final_hit", 32'(hit), 32'd1);

        // 4: test 1 again with idle gaps between valid bits
        set_cfg(4'b1011, 0, 0, 2);
        cyc(1, 1, 0, 0, 0, "t4_start");
        for (int i = 6; i >= 0; i--) begin
            int g = $urandom_range(1, 3);
            for (int j = 0; j < g; j++) cyc(0, 0, 0, 0, 1'($urandom), "t4_gap");
            cyc(0, 0, 0, 1, b7[i], "t4");
        end
        check_val("t4_final_cnt", 32'(match_cnt), 32'd2);

        // 5: config ignored while busy, abort, start+abort in IDLE
        set_cfg(4'b1011, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "t5_start");
        set_cfg(4'b0000, 4'b1111, 3, 1);
        cyc(1, 0, 0, 1, 1, "t5_busycfg");
        cyc(0, 0, 0, 1, 0, "t5_b2");
        cyc(0, 0, 1, 0, 0, "t5_abort");
        check_val("t5_abort_busy", 32'(busy), 32'd0);
        cyc(0, 1, 1, 0, 0, "t5_stab");
        cyc(0, 1, 0, 0, 0, "t5_restart");
        feed(5, 16'b10110, "t5_old_cfg");
        cyc(0, 0, 1, 0, 0, "t5_abort2");

        // 6: async reset mid-run, then a fresh run on reset config
        set_cfg(4'b1011, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "t6_start");
        feed(5, 16'b10110, "t6");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6_arst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(0, 1, 0, 0, 0, "t6_fresh");
        feed(5, 16'b00001, "t6_zero_pat");
        cyc(0, 0, 1, 0, 0, "t6_abort");

        // Short window ends during fill; saturation of the match counter
        set_cfg(4'b0101, 0, 2, 0);
        cyc(1, 1, 0, 0, 0, "short_start");
        feed(2, 16'b11, "short_win");
        set_cfg(0, 4'b1111, 0, 0);
        cyc(1, 1, 0, 0, 0, "sat_start");
        feed(14, 16'h2a5c, "sat");
        check_val("sat_cnt", 32'(match_cnt), 32'(CNT_SAT));
        cyc(0, 0, 1, 0, 0, "sat_abort");

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            int w;
            case ($urandom_range(0, 3))
                0: w = 0;
                1: w = $urandom_range(1, PW);
                default: w = $urandom_range(PW, 30);
            endcase
            set_cfg($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
                    w, $urandom_range(0, CNT_SAT));
            cyc(1, 1, 0, 0, 0, "rnd_start");
            for (int c = 0; c < 50; c++) begin
                bit cv = ($urandom_range(0, 7) == 0);
                if (cv) set_cfg($urandom_range(0, 15), $urandom_range(0, 15),
                                $urandom_range(0, 30), $urandom_range(0, CNT_SAT));
                cyc(cv, $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
                    $urandom_range(0, 9) < 7, 1'($urandom), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
